// File: rtl/hpdcache_pkg.sv
// hpdcache_pkg: shared cache configuration, CMO handler op encoding and core CMO op decode helpers.
package hpdcache_pkg;

   typedef struct packed {
      logic [31:0] ways;
   } hpdcache_user_cfg_t;

   typedef struct packed {
      hpdcache_user_cfg_t u;
   } hpdcache_cfg_t;

   typedef struct packed {
      logic is_fence;
      logic is_inval_by_nline;
      logic is_inval_by_set;
      logic is_inval_all;
   } hpdcache_cmoh_op_t;

   typedef enum logic [2:0] {
      HPDCACHE_CMO_FENCE       = 3'd0,
      HPDCACHE_CMO_INVAL_NLINE = 3'd1,
      HPDCACHE_CMO_INVAL_SET   = 3'd2,
      HPDCACHE_CMO_INVAL_ALL   = 3'd3
   } hpdcache_cmo_core_op_e;

   // Encodings 4..7 are reserved and must be answered with an error.
   function automatic logic cmo_op_legal(input logic [2:0] op);
      return !op[2];
   endfunction

   function automatic hpdcache_cmoh_op_t cmo_op_decode(input logic [2:0] op);
      hpdcache_cmoh_op_t r;
      r.is_fence          = op == HPDCACHE_CMO_FENCE;
      r.is_inval_by_nline = op == HPDCACHE_CMO_INVAL_NLINE;
      r.is_inval_by_set   = op == HPDCACHE_CMO_INVAL_SET;
      r.is_inval_all      = op == HPDCACHE_CMO_INVAL_ALL;
      return r;
   endfunction

endpackage

// File: rtl/hpdcache_cmo_issuer_if.sv
// hpdcache_cmo_issuer_if: core request/response and CMO handler channels of the CMO issuer.
interface hpdcache_cmo_issuer_if
   import hpdcache_pkg::*;
#(
   parameter type hpdcache_req_addr_t   = logic,
   parameter type hpdcache_req_data_t   = logic,
   parameter type hpdcache_req_tid_t    = logic,
   parameter type hpdcache_way_vector_t = logic
) ();

   logic                 core_req_valid_i;
   logic                 core_req_ready_o;
   logic [2:0]           core_req_op_i;
   hpdcache_req_addr_t   core_req_addr_i;
   hpdcache_way_vector_t core_req_way_i;
   hpdcache_req_tid_t    core_req_tid_i;
   logic                 core_req_need_rsp_i;

   logic                 cmo_req_valid_o;
   logic                 cmo_req_ready_i;
   hpdcache_cmoh_op_t    cmo_req_op_o;
   hpdcache_req_addr_t   cmo_req_addr_o;
   hpdcache_req_data_t   cmo_req_wdata_o;
   logic                 cmo_req_wait_i;

   logic                 core_rsp_valid_o;
   logic                 core_rsp_ready_i;
   hpdcache_req_tid_t    core_rsp_tid_o;
   logic                 core_rsp_error_o;

   modport master (
      output core_req_valid_i, core_req_op_i, core_req_addr_i, core_req_way_i,
             core_req_tid_i, core_req_need_rsp_i, cmo_req_ready_i, cmo_req_wait_i,
             core_rsp_ready_i,
      input  core_req_ready_o, cmo_req_valid_o, cmo_req_op_o, cmo_req_addr_o,
             cmo_req_wdata_o, core_rsp_valid_o, core_rsp_tid_o, core_rsp_error_o
   );

   modport slave (
      input  core_req_valid_i, core_req_op_i, core_req_addr_i, core_req_way_i,
             core_req_tid_i, core_req_need_rsp_i, cmo_req_ready_i, cmo_req_wait_i,
             core_rsp_ready_i,
      output core_req_ready_o, cmo_req_valid_o, cmo_req_op_o, cmo_req_addr_o,
             cmo_req_wdata_o, core_rsp_valid_o, core_rsp_tid_o, core_rsp_error_o
   );

endinterface

// File: rtl/hpdcache_cmo_issuer.sv
// hpdcache_cmo_issuer: accepts one core CMO request at a time, issues it to the CMO handler and returns completion.
module hpdcache_cmo_issuer
   import hpdcache_pkg::*;
#(
   parameter hpdcache_cfg_t HPDcacheCfg = '0,
   parameter type hpdcache_req_addr_t   = logic,
   parameter type hpdcache_req_data_t   = logic,
   parameter type hpdcache_req_tid_t    = logic,
   parameter type hpdcache_way_vector_t = logic,
   parameter int unsigned WaitCntWidth  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   hpdcache_cmo_issuer_if.slave    bus,
   output logic                    busy_o,
   output logic [WaitCntWidth-1:0] wait_cnt_o
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ISSUE     = 2'd1;
   localparam logic [1:0] WAIT_DONE = 2'd2;
   localparam logic [1:0] RESP      = 2'd3;

   localparam int unsigned Ways = HPDcacheCfg.u.ways;
   localparam logic [63:0] WayMask = (Ways >= 64) ? '1 : ((64'd1 << Ways) - 64'd1);

   logic [1:0]              state_q, state_d;
   logic                    need_rsp_q, need_rsp_d;
   logic                    err_q, err_d;
   logic [WaitCntWidth-1:0] cnt_q, cnt_d;
   hpdcache_cmoh_op_t       op_q;
   hpdcache_req_addr_t      addr_q;
   hpdcache_way_vector_t    way_q;
   hpdcache_req_tid_t       tid_q;
   logic                    accept, legal, issuing, responding;

   assign accept     = bus.core_req_valid_i && state_q == IDLE;
   assign legal      = cmo_op_legal(bus.core_req_op_i);
   assign issuing    = state_q == ISSUE;
   assign responding = state_q == RESP;

   always_comb begin
      state_d = state_q == IDLE      ? (bus.core_req_valid_i ? (legal ? ISSUE : RESP) : IDLE)
              : state_q == ISSUE     ? (bus.cmo_req_ready_i ? WAIT_DONE : ISSUE)
              : state_q == WAIT_DONE ? (bus.cmo_req_ready_i ? (need_rsp_q ? RESP : IDLE) : WAIT_DONE)
              :                        (bus.core_rsp_ready_i ? IDLE : RESP);
      need_rsp_d = accept ? bus.core_req_need_rsp_i : need_rsp_q;
      err_d      = accept ? !legal : (responding && bus.core_rsp_ready_i) ? 1'b0 : err_q;
      cnt_d      = (state_q == WAIT_DONE && bus.cmo_req_wait_i && !(&cnt_q))
                 ? cnt_q + WaitCntWidth'(1) : cnt_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         need_rsp_q <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         need_rsp_q <= need_rsp_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   // Datapath is only observed through state-gated outputs, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         op_q   <= cmo_op_decode(bus.core_req_op_i);
         addr_q <= bus.core_req_addr_i;
         way_q  <= bus.core_req_way_i;
         tid_q  <= bus.core_req_tid_i;
      end
   end

   assign bus.core_req_ready_o = state_q == IDLE;
   assign bus.cmo_req_valid_o  = issuing;
   assign bus.cmo_req_op_o     = issuing ? op_q : '0;
   assign bus.cmo_req_addr_o   = issuing ? addr_q : '0;
   assign bus.cmo_req_wdata_o  = issuing
                               ? hpdcache_req_data_t'(way_q & hpdcache_way_vector_t'(WayMask)) : '0;
   assign bus.core_rsp_valid_o = responding;
   assign bus.core_rsp_tid_o   = responding ? tid_q : '0;
   assign bus.core_rsp_error_o = responding && err_q;
   assign busy_o               = state_q != IDLE;
   assign wait_cnt_o           = cnt_q;

`ifndef HPDCACHE_ASSERT_OFF
   a_op_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
      bus.cmo_req_valid_o |-> $onehot(bus.cmo_req_op_o));
   a_cmo_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      bus.cmo_req_valid_o && !bus.cmo_req_ready_i |=> bus.cmo_req_valid_o
         && $stable(bus.cmo_req_op_o) && $stable(bus.cmo_req_addr_o) && $stable(bus.cmo_req_wdata_o));
   a_rsp_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      bus.core_rsp_valid_o && !bus.core_rsp_ready_i |=> bus.core_rsp_valid_o
         && $stable(bus.core_rsp_tid_o) && $stable(bus.core_rsp_error_o));
`endif

endmodule

// File: tb/tb_hpdcache_cmo_issuer.sv
// tb_hpdcache_cmo_issuer: directed CMO sequences with a queue scoreboard checked by a negedge monitor.
module tb_hpdcache_cmo_issuer;
   import hpdcache_pkg::*;

   typedef logic [31:0] addr_t;
   typedef logic [63:0] data_t;
   typedef logic [7:0]  tid_t;
   typedef logic [3:0]  way_t;

   localparam hpdcache_cfg_t Cfg = '{u: '{ways: 32'd4}};

   typedef struct { logic [3:0] op; addr_t addr; data_t wdata; } cmo_exp_t;
   typedef struct { tid_t tid; logic err; } rsp_exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       busy;
   logic [3:0] wait_cnt;
   int         vectors = 0;
   int         miscompares = 0;
   cmo_exp_t   cmo_q[$];
   rsp_exp_t   rsp_q[$];

   always #5 clk = ~clk;

   hpdcache_cmo_issuer_if #(
      .hpdcache_req_addr_t(addr_t), .hpdcache_req_data_t(data_t),
      .hpdcache_req_tid_t(tid_t), .hpdcache_way_vector_t(way_t)
   ) bus ();

   hpdcache_cmo_issuer #(
      .HPDcacheCfg(Cfg), .hpdcache_req_addr_t(addr_t), .hpdcache_req_data_t(data_t),
      .hpdcache_req_tid_t(tid_t), .hpdcache_way_vector_t(way_t), .WaitCntWidth(4)
   ) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus.slave), .busy_o(busy), .wait_cnt_o(wait_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation on every handshake and checks stability across stalls.
   logic     cmo_held = 1'b0, rsp_held = 1'b0;
   cmo_exp_t cmo_last, cmo_cur, cmo_e;
   rsp_exp_t rsp_last, rsp_cur, rsp_e;
   always @(negedge clk) begin
      cmo_cur.op    = {bus.cmo_req_op_o.is_fence, bus.cmo_req_op_o.is_inval_by_nline,
                       bus.cmo_req_op_o.is_inval_by_set, bus.cmo_req_op_o.is_inval_all};
      cmo_cur.addr  = bus.cmo_req_addr_o;
      cmo_cur.wdata = bus.cmo_req_wdata_o;
      rsp_cur.tid   = bus.core_rsp_tid_o;
      rsp_cur.err   = bus.core_rsp_error_o;
      if (rst) begin
         cmo_held = 1'b0;
         rsp_held = 1'b0;
      end else begin
         if (bus.cmo_req_valid_o) begin
            if (cmo_held) begin
               chk("cmo_stall_op", cmo_cur.op, cmo_last.op);
               chk("cmo_stall_addr", cmo_cur.addr, cmo_last.addr);
               chk("cmo_stall_wdata", cmo_cur.wdata, cmo_last.wdata);
            end
            if (bus.cmo_req_ready_i) begin
               cmo_held = 1'b0;
               if (cmo_q.size() == 0) chk("cmo_unexpected", 1, 0);
               else begin
                  cmo_e = cmo_q.pop_front();
                  chk("cmo_op", cmo_cur.op, cmo_e.op);
                  chk("cmo_addr", cmo_cur.addr, cmo_e.addr);
                  chk("cmo_wdata", cmo_cur.wdata, cmo_e.wdata);
               end
            end else begin
               cmo_held = 1'b1;
               cmo_last = cmo_cur;
            end
         end else if (cmo_held) begin
            chk("cmo_valid_dropped", 0, 1);
            cmo_held = 1'b0;
         end
         if (bus.core_rsp_valid_o) begin
            if (rsp_held) begin
               chk("rsp_stall_tid", rsp_cur.tid, rsp_last.tid);
               chk("rsp_stall_err", rsp_cur.err, rsp_last.err);
            end
            if (bus.core_rsp_ready_i) begin
               rsp_held = 1'b0;
               if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
               else begin
                  rsp_e = rsp_q.pop_front();
                  chk("rsp_tid", rsp_cur.tid, rsp_e.tid);
                  chk("rsp_err", rsp_cur.err, rsp_e.err);
               end
            end else begin
               rsp_held = 1'b1;
               rsp_last = rsp_cur;
            end
         end else if (rsp_held) begin
            chk("rsp_valid_dropped", 0, 1);
            rsp_held = 1'b0;
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents one request for exactly one accept cycle, then scrambles the core inputs.
   task automatic send(input logic [2:0] op, input addr_t a, input way_t w, input tid_t t,
                       input logic need, input logic [3:0] exp_op, input data_t exp_wd,
                       input logic exp_issue, input logic exp_rsp, input logic exp_err);
      int n = 0;
      while (!bus.core_req_ready_o && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("req_ready_timeout", n, 0);
      if (exp_issue) cmo_q.push_back('{exp_op, a, exp_wd});
      if (exp_rsp) rsp_q.push_back('{t, exp_err});
      bus.core_req_op_i       = op;
      bus.core_req_addr_i     = a;
      bus.core_req_way_i      = w;
      bus.core_req_tid_i      = t;
      bus.core_req_need_rsp_i = need;
      bus.core_req_valid_i    = 1'b1;
      tick();
      bus.core_req_valid_i    = 1'b0;
      bus.core_req_op_i       = 3'($urandom);
      bus.core_req_addr_i     = $urandom;
      bus.core_req_way_i      = 4'($urandom);
      bus.core_req_tid_i      = 8'($urandom);
      bus.core_req_need_rsp_i = 1'($urandom);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk(name, busy, 0);
   endtask

   initial begin
      bus.core_req_valid_i = 1'b0;
      bus.core_req_op_i = '0;
      bus.core_req_addr_i = '0;
      bus.core_req_way_i = '0;
      bus.core_req_tid_i = '0;
      bus.core_req_need_rsp_i = 1'b0;
      bus.cmo_req_ready_i = 1'b1;
      bus.cmo_req_wait_i = 1'b0;
      bus.core_rsp_ready_i = 1'b1;
      tick(2);
      chk("rst_req_ready", bus.core_req_ready_o, 1);
      chk("rst_busy", busy, 0);
      chk("rst_cmo_valid", bus.cmo_req_valid_o, 0);
      chk("rst_rsp_valid", bus.core_rsp_valid_o, 0);
      chk("rst_wait_cnt", wait_cnt, 0);
      rst = 1'b0;
      tick();

      // FENCE, handler always ready: issue in cycle 1, response in cycle 3.
      send(3'd0, 32'h100, 4'h0, 8'd5, 1'b1, 4'b1000, 64'h0, 1'b1, 1'b1, 1'b0);
      chk("fence_c1_cmo_valid", bus.cmo_req_valid_o, 1);
      chk("fence_c1_req_ready", bus.core_req_ready_o, 0);
      tick();
      chk("fence_c2_rsp_valid", bus.core_rsp_valid_o, 0);
      tick();
      chk("fence_c3_rsp_valid", bus.core_rsp_valid_o, 1);
      chk("fence_c3_rsp_tid", bus.core_rsp_tid_o, 5);
      tick();
      chk("fence_idle", bus.core_req_ready_o, 1);

      // INVAL_SET with handler stalled three cycles after accept.
      bus.cmo_req_ready_i = 1'b0;
      send(3'd2, 32'h2040, 4'b0101, 8'd3, 1'b1, 4'b0010, 64'h5, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("set_stall_cmo_valid", bus.cmo_req_valid_o, 1);
         chk("set_stall_rsp_valid", bus.core_rsp_valid_o, 0);
         tick();
      end
      bus.cmo_req_ready_i = 1'b1;
      tick();
      chk("set_wait_rsp_valid", bus.core_rsp_valid_o, 0);
      tick();
      chk("set_rsp_valid", bus.core_rsp_valid_o, 1);
      wait_idle("set_idle_timeout");

      // INVAL_NLINE without response; handler busy two cycles after the handshake.
      send(3'd1, 32'h3000, 4'hF, 8'd7, 1'b0, 4'b0100, 64'hF, 1'b1, 1'b0, 1'b0);
      tick();
      bus.cmo_req_ready_i = 1'b0;
      tick(2);
      chk("nline_busy", busy, 1);
      bus.cmo_req_ready_i = 1'b1;
      tick();
      chk("nline_idle", busy, 0);
      chk("nline_no_rsp", bus.core_rsp_valid_o, 0);

      // Illegal ops: no issue, error response even without need_rsp.
      send(3'd6, 32'h0, 4'h0, 8'd9, 1'b0, 4'b0, 64'h0, 1'b0, 1'b1, 1'b1);
      chk("ill6_cmo_valid", bus.cmo_req_valid_o, 0);
      chk("ill6_rsp_valid", bus.core_rsp_valid_o, 1);
      chk("ill6_rsp_err", bus.core_rsp_error_o, 1);
      wait_idle("ill6_idle_timeout");
      send(3'd7, 32'h0, 4'h0, 8'h22, 1'b1, 4'b0, 64'h0, 1'b0, 1'b1, 1'b1);
      wait_idle("ill7_idle_timeout");

      // INVAL_ALL: ten drain-wait cycles, response back-pressured four cycles.
      bus.core_rsp_ready_i = 1'b0;
      send(3'd3, 32'h0, 4'h0, 8'h2A, 1'b1, 4'b0001, 64'h0, 1'b1, 1'b1, 1'b0);
      tick();
      bus.cmo_req_ready_i = 1'b0;
      bus.cmo_req_wait_i = 1'b1;
      tick(10);
      bus.cmo_req_ready_i = 1'b1;
      bus.cmo_req_wait_i = 1'b0;
      chk("all_wait_cnt", wait_cnt, 10);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("all_rsp_held_valid", bus.core_rsp_valid_o, 1);
         chk("all_rsp_held_tid", bus.core_rsp_tid_o, 8'h2A);
         chk("all_rsp_held_err", bus.core_rsp_error_o, 0);
         tick();
      end
      bus.core_rsp_ready_i = 1'b1;
      wait_idle("all_idle_timeout");
      chk("all_wait_cnt_kept", wait_cnt, 10);

      // Asynchronous reset during WAIT_DONE drops the pending response.
      send(3'd1, 32'h4000, 4'h0, 8'h33, 1'b1, 4'b0100, 64'h0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.cmo_req_ready_i = 1'b0;
      bus.cmo_req_wait_i = 1'b1;
      tick();
      chk("rstmid_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_async_ready", bus.core_req_ready_o, 1);
      chk("rstmid_async_cnt", wait_cnt, 0);
      tick();
      rst = 1'b0;
      bus.cmo_req_ready_i = 1'b1;
      bus.cmo_req_wait_i = 1'b0;
      tick();
      chk("rstmid_req_ready", bus.core_req_ready_o, 1);
      chk("rstmid_busy_after", busy, 0);
      for (int i = 0; i < 3; i++) begin
         chk("rstmid_no_rsp", bus.core_rsp_valid_o, 0);
         tick();
      end

      // Four-bit counter saturates after twenty wait cycles.
      send(3'd3, 32'h0, 4'h0, 8'h44, 1'b0, 4'b0001, 64'h0, 1'b1, 1'b0, 1'b0);
      tick();
      bus.cmo_req_ready_i = 1'b0;
      bus.cmo_req_wait_i = 1'b1;
      tick(20);
      bus.cmo_req_ready_i = 1'b1;
      bus.cmo_req_wait_i = 1'b0;
      chk("sat_wait_cnt", wait_cnt, 15);
      tick();
      chk("sat_idle", busy, 0);

      tick(2);
      chk("cmo_expect_left", cmo_q.size(), 0);
      chk("rsp_expect_left", rsp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
